instr_fetch_stage: RTL and testbench
====================================

# instr_fetch_stage

Fetch front end that sits directly upstream of the IF/ID pipeline register. It owns the fetch PC, reads the combinational instruction memory, and buffers fetched words with their PC+4 in a small prefetch queue. It hands words to decode over a valid/ready handshake and flushes and re-steers on a branch redirect from the EX/MEM stage.

## Interface
- DEPTH, 4: prefetch queue entries (power of two, ≥2).
- RESET_PC, 32'h0000_0000: fetch address after reset.
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_addr  out  32  instruction memory address; always equals the fetch PC.
- imem_rdata  in  32  instruction word at imem_addr, valid in the same cycle.
- redirect_valid  in  1  branch taken in MEM (PCsrc); flush and re-steer.
- redirect_pc  in  32  branch target; bits [1:0] are ignored and treated as 0.
- id_valid  out  1  queue head valid.
- id_ready  in  1  decode accepts the head this cycle.
- id_instr  out  32  head instruction.
- id_pc_plus4  out  32  head PC+4.
- id_pred_taken  out  1  head was predicted taken (see Configuration).
- fifo_count  out  $clog2(DEPTH)+1  occupied entries.

## Operation
- pop = id_valid & id_ready. push = !redirect_valid & (fifo_count < DEPTH | pop).
- push: write {imem_rdata, imem_addr+4, pred} at the tail; the fetch PC advances to its next value (imem_addr+4, or the predicted target).
- No push: the fetch PC holds.
- Full with simultaneous pop: push is allowed and the count is unchanged.
- redirect_valid: takes priority over push.
  - At the edge the queue empties (count=0) and the fetch PC loads {redirect_pc[31:2],2'b00}.
  - A pop in the same cycle is a completed transfer; squashing that word downstream is the consumer's job.
- Fetch PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 wraps to 0.
- id_valid = (fifo_count != 0). It is registered state only, with no combinational path from id_ready or redirect_valid.
- id_instr, id_pc_plus4 and id_pred_taken are the head entry. Their values are undefined while id_valid=0, except immediately after reset.
- Queue order is strict FIFO: no loss, no duplication, no reordering.

## Timing
- Reset values (applied asynchronously):
  - imem_addr = RESET_PC.
  - id_valid = 0, fifo_count = 0.
  - id_instr = 0, id_pc_plus4 = 0, id_pred_taken = 0.
  - Queue storage is cleared.
- Reset asserted mid-operation: all state returns to reset values immediately, regardless of the clock.
- Fetch-to-decode latency is 1 cycle. The word at PC is pushed on edge N and id_valid=1 after edge N.
- First edge after reset release pushes the word at RESET_PC; id_valid rises after that edge.
- Redirect asserted before edge N:
  - after N: id_valid=0, imem_addr = target;
  - edge N+1 pushes the target word;
  - id_valid=1 after N+1.
- Throughput: 1 word/cycle sustained while id_ready=1.

## Configuration
- FETCH_BTFN_EN defined:
  - Each pushed word is predecoded.
  - If opcode[31:26] = 6'b000100 (beq) and imm[15] = 1, the next fetch PC = imem_addr + 4 + (sext(imm[15:0]) << 2), and the entry's pred bit is 1.
  - All other words fetch sequentially with pred = 0.
- FETCH_BTFN_EN undefined: no predecode; fetch is purely sequential, id_pred_taken is tied to 0, and the predecode logic is absent.

## Structure
- Package fetch_pkg holds:
  - INSTR_W = 32;
  - OPC_BEQ = 6'b000100;
  - the fetch_entry_t struct {instr, pc_plus4, pred_taken};
  - a next_pc_seq(pc) function.
- Sub-module fetch_queue: a parameterized synchronous FIFO with
  - async reset and flush;
  - push/pop/full/empty/count;
  - simultaneous push+pop at full.
- instr_fetch_stage contains the PC register, the push/redirect logic, and the optional predecode.

## Test plan
- Reset streaming: RESET_PC=0, imem_rdata = 32'hA000_0000 | imem_addr, id_ready=1.
  - id_valid rises one edge after reset release.
  - Heads are A0000000, A0000004, A0000008 with id_pc_plus4 = 4, 8, 12 on consecutive cycles.
- Backpressure: id_ready=0 for 10 cycles from reset.
  - fifo_count saturates at 4 and imem_addr holds at 0x10.
  - Release id_ready: heads arrive in order 0x0, 0x4, 0x8, 0xC, 0x10 with no gaps or duplicates.
- Redirect while full: redirect_pc = 0x103 with the queue full.
  - Next cycle: id_valid=0, fifo_count=0, imem_addr=0x100.
  - Following cycle: head pc_plus4 = 0x104.
- Redirect with simultaneous pop: the popped word is counted as transferred exactly once; all other entries are discarded.
- BTFN: word at 0x20 = beq with imm = 16'hFFFE.
  - With FETCH_BTFN_EN: the next imem_addr is 0x1C and the head's id_pred_taken=1.
  - Without it: the next imem_addr is 0x24 and id_pred_taken=0.
- Async reset mid-stream: assert rst between clock edges with 3 entries queued.
  - Immediately: id_valid=0, fifo_count=0, imem_addr=RESET_PC.
  - After release: streaming restarts from RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

    localparam int         INSTR_W = 32;
    localparam logic [5:0] OPC_BEQ = 6'b000100;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [31:0]        pc_plus4;
        logic               pred_taken;
    } fetch_entry_t;

    function automatic logic [31:0] next_pc_seq(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/instr_fetch_stage_if.sv
// Fetch-stage bus: instruction memory port, redirect input and decode handshake.
interface instr_fetch_stage_if #(
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [31:0]      imem_addr;
    logic [31:0]      imem_rdata;
    logic             redirect_valid;
    logic [31:0]      redirect_pc;
    logic             id_valid;
    logic             id_ready;
    logic [31:0]      id_instr;
    logic [31:0]      id_pc_plus4;
    logic             id_pred_taken;
    logic [CNT_W-1:0] fifo_count;

    modport master (
        output imem_addr,
        input  imem_rdata,
        input  redirect_valid,
        input  redirect_pc,
        output id_valid,
        input  id_ready,
        output id_instr,
        output id_pc_plus4,
        output id_pred_taken,
        output fifo_count
    );

    modport slave (
        input  imem_addr,
        output imem_rdata,
        output redirect_valid,
        output redirect_pc,
        input  id_valid,
        output id_ready,
        input  id_instr,
        input  id_pc_plus4,
        input  id_pred_taken,
        input  fifo_count
    );

endinterface

// File: rtl/fetch_queue.sv
// Prefetch FIFO with async reset, synchronous flush and push+pop at full.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH) + 1,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  fetch_entry_t     wdata,
    output fetch_entry_t     rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign rdata = mem[rd_ptr];

    // NOTE: storage is reset too, so the head reads as all-zero straight out of reset.
    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch_stage.sv
// Fetch PC, redirect handling and prefetch queue feeding IF/ID.
// Optional backward-taken branch prediction is enabled by defining FETCH_BTFN_EN.
module instr_fetch_stage
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    localparam int         CNT_W    = $clog2(DEPTH) + 1
) (
    input  logic           clk,
    input  logic           rst,
    instr_fetch_stage_if.master bus
);

    logic [31:0]      pc;
    logic [31:0]      pc_seq;
    logic [31:0]      pc_next;
    logic             pred;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic [CNT_W-1:0] count;
    fetch_entry_t     wr_entry;
    fetch_entry_t     head;

    assign pc_seq = next_pc_seq(pc);
    assign pop    = !empty && bus.id_ready;
    assign push   = !bus.redirect_valid && (!full || pop);

`ifdef FETCH_BTFN_EN
    logic [31:0] br_target;

    // Backward beq (negative offset) is predicted taken.
    assign br_target = pc_seq + {{14{bus.imem_rdata[15]}}, bus.imem_rdata[15:0], 2'b00};

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        pred    = 1'b0;
        pc_next = pc_seq;
        if (bus.imem_rdata[31:26] == OPC_BEQ && bus.imem_rdata[15]) begin
            pred    = 1'b1;
            pc_next = br_target;
        end
    end
`else
    assign pred    = 1'b0;
    assign pc_next = pc_seq;
`endif

    assign wr_entry = '{instr: bus.imem_rdata, pc_plus4: pc_seq, pred_taken: pred};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (bus.redirect_valid) begin
            pc <= {bus.redirect_pc[31:2], 2'b00};
        end else if (push) begin
            pc <= pc_next;
        end
    end

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk   (clk),
        .rst   (rst),
        .flush (bus.redirect_valid),
        .push  (push),
        .pop   (pop),
        .wdata (wr_entry),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign bus.imem_addr     = pc;
    assign bus.id_valid      = !empty;
    assign bus.id_instr      = head.instr;
    assign bus.id_pc_plus4   = head.pc_plus4;
    assign bus.id_pred_taken = head.pred_taken;
    assign bus.fifo_count    = count;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Scoreboard bench for instr_fetch_stage: directed scenarios push expected words,
// a negedge monitor compares every completed decode transfer.
module tb_instr_fetch_stage;
    import fetch_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic beq_at_20 = 1'b0;

    int vectors     = 0;
    int miscompares = 0;

    fetch_entry_t exp_q[$];

    instr_fetch_stage_if #(.DEPTH(4)) bus ();

    instr_fetch_stage #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Instruction memory model: tagged address, with an optional backward beq at 0x20.
    always_comb begin
        bus.imem_rdata = 32'hA000_0000 | bus.imem_addr;
        if (beq_at_20 && bus.imem_addr == 32'h20) begin
            bus.imem_rdata = 32'h1000_FFFE;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_word(input logic [31:0] instr, input logic [31:0] pc4, input logic pred);
        exp_q.push_back('{instr: instr, pc_plus4: pc4, pred_taken: pred});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst                = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.id_ready       = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic check_drained(input string name);
        check(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    // Monitor: a transfer completes on the next edge whenever valid & ready hold at negedge.
    always @(negedge clk) begin
        if (!rst && bus.id_valid && bus.id_ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_xfer: got instr %h pc_plus4 %h expected no transfer",
                         bus.id_instr, bus.id_pc_plus4);
            end else begin
                fetch_entry_t e;
                e = exp_q.pop_front();
                check("xfer_instr", bus.id_instr, e.instr);
                check("xfer_pc_plus4", bus.id_pc_plus4, e.pc_plus4);
                check("xfer_pred", 32'(bus.id_pred_taken), 32'(e.pred_taken));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.id_ready       = 1'b1;

        // Reset streaming
        tick();
        check("rst_valid", 32'(bus.id_valid), 32'd0);
        check("rst_count", 32'(bus.fifo_count), 32'd0);
        check("rst_addr", bus.imem_addr, 32'h0);
        check("rst_instr", bus.id_instr, 32'h0);
        check("rst_pc_plus4", bus.id_pc_plus4, 32'h0);
        check("rst_pred", 32'(bus.id_pred_taken), 32'd0);
        rst = 1'b0;
        expect_word(32'hA000_0000, 32'h4, 1'b0);
        expect_word(32'hA000_0004, 32'h8, 1'b0);
        expect_word(32'hA000_0008, 32'hC, 1'b0);
        check("stream_valid_pre", 32'(bus.id_valid), 32'd0);
        tick();
        check("stream_valid", 32'(bus.id_valid), 32'd1);
        repeat (3) tick();
        bus.id_ready = 1'b0;
        check("stream_count", 32'(bus.fifo_count), 32'd1);
        check_drained("stream_drained");

        // Backpressure from reset, then release
        reset_dut();
        repeat (10) tick();
        check("bp_count_full", 32'(bus.fifo_count), 32'd4);
        check("bp_addr_hold", bus.imem_addr, 32'h10);
        for (int i = 0; i < 5; i++) begin
            expect_word(32'hA000_0000 | 32'(i * 4), 32'(i * 4 + 4), 1'b0);
        end
        bus.id_ready = 1'b1;
        repeat (5) tick();
        bus.id_ready = 1'b0;
        check("bp_count_after", 32'(bus.fifo_count), 32'd4);
        check("bp_addr_after", bus.imem_addr, 32'h24);
        check_drained("bp_drained");

        // Redirect while full, misaligned target
        reset_dut();
        repeat (6) tick();
        check("rdf_full", 32'(bus.fifo_count), 32'd4);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h103;
        tick();
        bus.redirect_valid = 1'b0;
        check("rdf_valid", 32'(bus.id_valid), 32'd0);
        check("rdf_count", 32'(bus.fifo_count), 32'd0);
        check("rdf_addr", bus.imem_addr, 32'h100);
        expect_word(32'hA000_0100, 32'h104, 1'b0);
        bus.id_ready = 1'b1;
        tick();
        check("rdf_valid_next", 32'(bus.id_valid), 32'd1);
        check("rdf_head_pc4", bus.id_pc_plus4, 32'h104);
        tick();
        bus.id_ready = 1'b0;
        check_drained("rdf_drained");

        // Redirect with simultaneous pop
        reset_dut();
        repeat (3) tick();
        check("rdp_count3", 32'(bus.fifo_count), 32'd3);
        expect_word(32'hA000_0000, 32'h4, 1'b0);
        bus.id_ready       = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h40;
        tick();
        bus.redirect_valid = 1'b0;
        check("rdp_count0", 32'(bus.fifo_count), 32'd0);
        check("rdp_valid", 32'(bus.id_valid), 32'd0);
        check("rdp_addr", bus.imem_addr, 32'h40);
        expect_word(32'hA000_0040, 32'h44, 1'b0);
        tick();
        tick();
        bus.id_ready = 1'b0;
        check("rdp_count_end", 32'(bus.fifo_count), 32'd1);
        check("rdp_addr_end", bus.imem_addr, 32'h48);
        check_drained("rdp_drained");

        // Backward beq at 0x20
        reset_dut();
        beq_at_20          = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h20;
        tick();
        bus.redirect_valid = 1'b0;
        check("btfn_addr20", bus.imem_addr, 32'h20);
        tick();
`ifdef FETCH_BTFN_EN
        check("btfn_next_addr", bus.imem_addr, 32'h1C);
        expect_word(32'h1000_FFFE, 32'h24, 1'b1);
`else
        check("btfn_next_addr", bus.imem_addr, 32'h24);
        expect_word(32'h1000_FFFE, 32'h24, 1'b0);
`endif
        bus.id_ready = 1'b1;
        tick();
        bus.id_ready = 1'b0;
        beq_at_20    = 1'b0;
        check_drained("btfn_drained");

        // Asynchronous reset mid-stream
        reset_dut();
        repeat (3) tick();
        check("arst_count3", 32'(bus.fifo_count), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", 32'(bus.id_valid), 32'd0);
        check("arst_count", 32'(bus.fifo_count), 32'd0);
        check("arst_addr", bus.imem_addr, 32'h0);
        check("arst_instr", bus.id_instr, 32'h0);
        tick();
        rst = 1'b0;
        expect_word(32'hA000_0000, 32'h4, 1'b0);
        expect_word(32'hA000_0004, 32'h8, 1'b0);
        bus.id_ready = 1'b1;
        tick();
        check("arst_restart_valid", 32'(bus.id_valid), 32'd1);
        tick();
        tick();
        bus.id_ready = 1'b0;
        check_drained("arst_drained");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
